// File: rtl/axis_cpu_loader_if.sv
// -----------------------------------------------------------------------------
// axis_cpu_loader_if
//
// Bundles the two buses of axis_cpu_loader:
//   - the image-memory read port: img_addr, img_rd_en, and img_data, which
//     is valid one cycle after img_rd_en.
//   - the outgoing command stream: cmd_out_TDATA and cmd_out_TVALID. There
//     is no TREADY.
//
// Modports:
//   master : the loader side. It drives the address, strobe and stream, and
//            receives img_data.
//   slave  : the memory and receiver side.
// -----------------------------------------------------------------------------
interface axis_cpu_loader_if #(
  parameter int CODE_ADDR_WIDTH = 10
);
  logic [CODE_ADDR_WIDTH:0] img_addr;
  logic                     img_rd_en;
  logic [31:0]              img_data;
  logic [31:0]              cmd_out_TDATA;
  logic                     cmd_out_TVALID;

  modport master (
    output img_addr,
    output img_rd_en,
    input  img_data,
    output cmd_out_TDATA,
    output cmd_out_TVALID
  );

  modport slave (
    input  img_addr,
    input  img_rd_en,
    output img_data,
    input  cmd_out_TDATA,
    input  cmd_out_TVALID
  );
endinterface

// File: rtl/axis_cpu_loader.sv
// -----------------------------------------------------------------------------
// axis_cpu_loader
//
// Programs one axis_cpu over its cmd_in daisy-chain. On an accepted start
// request, the loader emits a series of two-beat register writes in this
// order:
//   1. PROG=1.
//   2. One write per instruction word.
//   3. One write per jump offset.
//   4. One write per immediate.
//   5. PROG=0.
// Instruction, jump-offset and immediate payloads are read from a synchronous
// image memory through a single running address counter. Each write is an
// address beat ({dest_id, reg}) followed by a data beat. After each data beat,
// the stream stays idle for GAP cycles.
//
// Ports:
//   clk, rstn         clock; asynchronous active-low reset
//   start             load request, accepted only while start_ready=1
//   start_ready       high in IDLE
//   dest_id           target CPU_ID, latched on accept
//   n_inst            instruction count, clamped to 2^CODE_ADDR_WIDTH
//   n_jmp, n_imm      jump-offset and immediate counts, each clamped to 16
//   abort             finish the current pair, then jump to PROG=0
//   busy              high whenever not IDLE
//   done              one-cycle pulse on return to IDLE
//   aborted           sticky abort flag, cleared on the next accept
//   bus               image read port and command stream (master modport)
// -----------------------------------------------------------------------------
module axis_cpu_loader #(
  parameter int CODE_ADDR_WIDTH = 10,
  parameter int REG_ADDR_WIDTH  = 4,
  parameter int CPU_ID_WIDTH    = 12,
  parameter int REG_PROG        = 0,
  parameter int REG_INST        = 1,
  parameter int REG_JMP_OFF     = 2,
  parameter int REG_IMM         = 3,
  parameter int GAP             = 0
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  output logic                      start_ready,
  input  logic [CPU_ID_WIDTH-1:0]   dest_id,
  input  logic [CODE_ADDR_WIDTH:0]  n_inst,
  input  logic [4:0]                n_jmp,
  input  logic [4:0]                n_imm,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic                      aborted,
  axis_cpu_loader_if.master         bus
);

  localparam int CW = CODE_ADDR_WIDTH + 1;
  localparam logic [CODE_ADDR_WIDTH:0] MAX_INST = CW'(1) << CODE_ADDR_WIDTH;
  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE, S_PON, S_INST, S_JMP, S_IMM, S_POFF
  } state_t;

  // Position inside one write. PH_TAIL is the single idle cycle after the
  // PROG=0 write, before the FSM returns to IDLE.
  typedef enum logic [1:0] {
    PH_ADDR, PH_DATA, PH_GAP, PH_TAIL
  } phase_t;

  state_t                   state;
  phase_t                   phase;
  logic [3:0]               gap_cnt;
  logic [CPU_ID_WIDTH-1:0]  dest_q;
  logic [CODE_ADDR_WIDTH:0] inst_left;
  logic [4:0]               jmp_left;
  logic [4:0]               imm_left;
  logic [CODE_ADDR_WIDTH:0] addr_q;
  logic                     abort_pend;

  logic [31:0]              tdata_q;
  logic                     use_img_q;
  logic                     tvalid_q;
  logic                     rd_en_q;
  logic [CODE_ADDR_WIDTH:0] img_addr_q;

  logic [CODE_ADDR_WIDTH:0] n_inst_c;
  logic [4:0]               n_jmp_c;
  logic [4:0]               n_imm_c;
  logic                     pair_end;
  logic                     abort_take;
  state_t                   next_sec;

  function automatic logic [REG_ADDR_WIDTH-1:0] reg_of(input state_t s);
    case (s)
      S_INST:  reg_of = REG_ADDR_WIDTH'(REG_INST);
      S_JMP:   reg_of = REG_ADDR_WIDTH'(REG_JMP_OFF);
      S_IMM:   reg_of = REG_ADDR_WIDTH'(REG_IMM);
      default: reg_of = REG_ADDR_WIDTH'(REG_PROG);
    endcase
  endfunction

  function automatic logic [31:0] addr_word(input logic [CPU_ID_WIDTH-1:0] id,
                                            input state_t s);
    addr_word = '0;
    addr_word[REG_ADDR_WIDTH+CPU_ID_WIDTH-1:REG_ADDR_WIDTH] = id;
    addr_word[REG_ADDR_WIDTH-1:0] = reg_of(s);
  endfunction

  function automatic logic is_mem(input state_t s);
    is_mem = (s == S_INST) || (s == S_JMP) || (s == S_IMM);
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave
    // a signal unassigned and infer a latch.
    n_inst_c   = n_inst;
    n_jmp_c    = n_jmp;
    n_imm_c    = n_imm;
    pair_end   = 1'b0;
    abort_take = 1'b0;
    next_sec   = S_POFF;

    if (n_inst > MAX_INST) n_inst_c = MAX_INST;
    if (n_jmp > 5'd16)     n_jmp_c  = 5'd16;
    if (n_imm > 5'd16)     n_imm_c  = 5'd16;

    // A write is over after its data beat, or after its last gap cycle.
    if (state != S_IDLE) begin
      if (phase == PH_DATA && GAP == 0)        pair_end = 1'b1;
      if (phase == PH_GAP && gap_cnt == 4'd0)  pair_end = 1'b1;
    end

    abort_take = abort && (state == S_PON || state == S_INST ||
                           state == S_JMP || state == S_IMM);

    // The per-section counters decrement as writes launch, so a fixed
    // priority picks the next non-empty section from any point.
    if (!(abort || abort_pend)) begin
      if (inst_left != '0)     next_sec = S_INST;
      else if (jmp_left != '0) next_sec = S_JMP;
      else if (imm_left != '0) next_sec = S_IMM;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      phase       <= PH_ADDR;
      gap_cnt     <= '0;
      dest_q      <= '0;
      inst_left   <= '0;
      jmp_left    <= '0;
      imm_left    <= '0;
      addr_q      <= '0;
      abort_pend  <= 1'b0;
      tdata_q     <= '0;
      use_img_q   <= 1'b0;
      tvalid_q    <= 1'b0;
      rd_en_q     <= 1'b0;
      img_addr_q  <= '0;
      start_ready <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      done    <= 1'b0;
      rd_en_q <= 1'b0;

      if (abort_take) begin
        abort_pend <= 1'b1;
        aborted    <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            dest_q      <= dest_id;
            inst_left   <= n_inst_c;
            jmp_left    <= n_jmp_c;
            imm_left    <= n_imm_c;
            addr_q      <= '0;
            abort_pend  <= 1'b0;
            aborted     <= 1'b0;
            busy        <= 1'b1;
            start_ready <= 1'b0;
            state       <= S_PON;
            phase       <= PH_ADDR;
            tvalid_q    <= 1'b1;
            use_img_q   <= 1'b0;
            tdata_q     <= addr_word(dest_id, S_PON);
          end
        end

        default: begin
          if (pair_end) begin
            if (state == S_POFF) begin
              phase     <= PH_TAIL;
              tvalid_q  <= 1'b0;
              use_img_q <= 1'b0;
              tdata_q   <= '0;
            end else begin
              // Launch the address beat of the next write. For memory
              // sections, the read issues now, so img_data is ready for the
              // data beat.
              state     <= next_sec;
              phase     <= PH_ADDR;
              tvalid_q  <= 1'b1;
              use_img_q <= 1'b0;
              tdata_q   <= addr_word(dest_q, next_sec);
              if (is_mem(next_sec)) begin
                rd_en_q    <= 1'b1;
                img_addr_q <= addr_q;
                addr_q     <= addr_q + 1'b1;
              end
              case (next_sec)
                S_INST:  inst_left <= inst_left - 1'b1;
                S_JMP:   jmp_left  <= jmp_left - 1'b1;
                S_IMM:   imm_left  <= imm_left - 1'b1;
                default: ;
              endcase
            end
          end else begin
            case (phase)
              PH_ADDR: begin
                phase     <= PH_DATA;
                tvalid_q  <= 1'b1;
                tdata_q   <= (state == S_PON) ? 32'h1 : 32'h0;
                use_img_q <= is_mem(state);
              end
              PH_DATA: begin
                // Reached only when GAP > 0; with GAP == 0, the data beat is
                // a pair end.
                phase     <= PH_GAP;
                gap_cnt   <= GAP_LAST;
                tvalid_q  <= 1'b0;
                use_img_q <= 1'b0;
                tdata_q   <= '0;
              end
              PH_GAP: begin
                gap_cnt <= gap_cnt - 1'b1;
              end
              PH_TAIL: begin
                state       <= S_IDLE;
                phase       <= PH_ADDR;
                done        <= 1'b1;
                busy        <= 1'b0;
                start_ready <= 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

  // img_data arrives straight from the synchronous memory's output register
  // in the data-beat cycle, so it is passed through rather than re-registered.
  assign bus.cmd_out_TDATA  = use_img_q ? bus.img_data : tdata_q;
  assign bus.cmd_out_TVALID = tvalid_q;
  assign bus.img_rd_en      = rd_en_q;
  assign bus.img_addr       = img_addr_q;

endmodule

// File: tb/tb_axis_cpu_loader.sv
// -----------------------------------------------------------------------------
// tb_axis_cpu_loader
//
// Two loader instances share one image memory: dut0 has GAP=0 and dut3 has
// GAP=3. The bench model expands each load into expected beats, each with the
// cycle at which it must appear relative to the accept edge. A negedge monitor
// pops and compares the beats as the selected instance emits them.
// -----------------------------------------------------------------------------
module tb_axis_cpu_loader;

  localparam int CAW = 10;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        start0 = 1'b0, start3 = 1'b0;
  logic [11:0] dest_id = '0;
  logic [10:0] n_inst = '0;
  logic [4:0]  n_jmp = '0, n_imm = '0;
  logic        abort = 1'b0;
  logic        sr0, sr3, busy0, busy3, done0, done3, ab0, ab3;

  axis_cpu_loader_if #(.CODE_ADDR_WIDTH(CAW)) bus0 ();
  axis_cpu_loader_if #(.CODE_ADDR_WIDTH(CAW)) bus3 ();

  axis_cpu_loader #(.CODE_ADDR_WIDTH(CAW), .GAP(0)) dut0 (
    .clk(clk), .rstn(rstn), .start(start0), .start_ready(sr0),
    .dest_id(dest_id), .n_inst(n_inst), .n_jmp(n_jmp), .n_imm(n_imm),
    .abort(abort), .busy(busy0), .done(done0), .aborted(ab0), .bus(bus0)
  );

  axis_cpu_loader #(.CODE_ADDR_WIDTH(CAW), .GAP(3)) dut3 (
    .clk(clk), .rstn(rstn), .start(start3), .start_ready(sr3),
    .dest_id(dest_id), .n_inst(n_inst), .n_jmp(n_jmp), .n_imm(n_imm),
    .abort(abort), .busy(busy3), .done(done3), .aborted(ab3), .bus(bus3)
  );

  // Synchronous image memory: data is valid one cycle after the read strobe.
  logic [31:0] mem [0:2047];
  always @(posedge clk) begin
    if (bus0.img_rd_en) bus0.img_data <= mem[bus0.img_addr];
    if (bus3.img_rd_en) bus3.img_data <= mem[bus3.img_addr];
  end

  // View of whichever instance the current test drives.
  logic        sel = 1'b0;
  logic        m_start, m_sr, m_tvalid, m_rd, m_done, m_ab, m_busy;
  logic [31:0] m_tdata;
  logic [10:0] m_addr;
  assign m_start  = sel ? start3 : start0;
  assign m_sr     = sel ? sr3 : sr0;
  assign m_tvalid = sel ? bus3.cmd_out_TVALID : bus0.cmd_out_TVALID;
  assign m_tdata  = sel ? bus3.cmd_out_TDATA : bus0.cmd_out_TDATA;
  assign m_rd     = sel ? bus3.img_rd_en : bus0.img_rd_en;
  assign m_addr   = sel ? bus3.img_addr : bus0.img_addr;
  assign m_done   = sel ? done3 : done0;
  assign m_ab     = sel ? ab3 : ab0;
  assign m_busy   = sel ? busy3 : busy0;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } beat_t;

  beat_t exp_q[$];

  // Cycles since the accept edge; 0 in the first beat's cycle.
  int acc_cnt = 0;
  always @(posedge clk) begin
    if (m_start && m_sr) acc_cnt <= 0;
    else                 acc_cnt <= acc_cnt + 1;
  end

  bit          mon_en = 1'b0;
  int          beat_cnt, rd_cnt, done_cnt, done_at;
  logic [10:0] last_addr;

  always @(negedge clk) begin
    if (rstn && mon_en) begin
      if (m_tvalid) begin
        beat_cnt++;
        if (exp_q.size() > 0) begin
          beat_t b;
          b = exp_q.pop_front();
          check("beat_data", m_tdata, b.data);
          check("beat_cycle", acc_cnt, b.cyc);
        end
      end
      if (m_rd) begin
        rd_cnt++;
        last_addr = m_addr;
      end
      if (m_done) begin
        done_cnt++;
        done_at = acc_cnt;
        check("ready_at_done", {31'b0, m_sr}, 32'd1);
      end
    end
  end

  function automatic logic [31:0] aword(input logic [11:0] d, input int r);
    aword = {16'h0, d, 4'(r)};
  endfunction

  task automatic push_write(input int w, input logic [31:0] a,
                            input logic [31:0] p, input int gap);
    beat_t b;
    b.data = a; b.cyc = (2 + gap) * w;     exp_q.push_back(b);
    b.data = p; b.cyc = (2 + gap) * w + 1; exp_q.push_back(b);
  endtask

  // One complete load. abort_at: write index during whose data beat abort is
  // held (-1 = none). busy_start_at: cycle at which start is pulsed mid-run.
  task automatic run_load(input bit s, input logic [11:0] d,
                          input logic [10:0] ni, input logic [4:0] nj,
                          input logic [4:0] nm, input int abort_at,
                          input int busy_start_at);
    int gap, ni_c, nj_c, nm_c, w, a, total, r, exp_done;
    gap  = s ? 3 : 0;
    ni_c = (ni > 11'd1024) ? 1024 : int'(ni);
    nj_c = (nj > 5'd16) ? 16 : int'(nj);
    nm_c = (nm > 5'd16) ? 16 : int'(nm);

    exp_q.delete();
    beat_cnt = 0; rd_cnt = 0; done_cnt = 0; done_at = -1; last_addr = '0;

    w = 0; a = 0;
    push_write(w, aword(d, 0), 32'h1, gap); w++;
    total = ni_c + nj_c + nm_c;
    for (int k = 0; k < total; k++) begin
      if (abort_at >= 0 && w > abort_at) break;
      r = (k < ni_c) ? 1 : (k < ni_c + nj_c) ? 2 : 3;
      push_write(w, aword(d, r), mem[a], gap);
      a++; w++;
    end
    push_write(w, aword(d, 0), 32'h0, gap); w++;
    exp_done = (2 + gap) * w + 1;

    @(negedge clk);
    sel = s; dest_id = d; n_inst = ni; n_jmp = nj; n_imm = nm;
    if (s) start3 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start3 = 1'b0;

    for (int c = 0; c < exp_done + 8; c++) begin
      abort = (abort_at >= 0) && (acc_cnt == (2 + gap) * abort_at + 1);
      if ((busy_start_at >= 0) && (acc_cnt == busy_start_at)) begin
        if (s) start3 = 1'b1; else start0 = 1'b1;
      end else begin
        start0 = 1'b0; start3 = 1'b0;
      end
      @(negedge clk);
    end
    abort = 1'b0; start0 = 1'b0; start3 = 1'b0;

    check("done_count", done_cnt, 32'd1);
    check("done_cycle", done_at, exp_done);
    check("beat_count", beat_cnt, 2 * w);
    check("read_count", rd_cnt, a);
    if (a > 0) check("last_addr", {21'b0, last_addr}, a - 1);
    check("aborted", {31'b0, m_ab}, {31'b0, (abort_at >= 0)});
    check("idle_ready", {31'b0, m_sr}, 32'd1);
    check("idle_busy", {31'b0, m_busy}, 32'd0);
    check("leftover", exp_q.size(), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = $urandom;

    // Reset state.
    #12;
    check("rst_ready", {31'b0, sr0}, 32'd1);
    check("rst_busy", {31'b0, busy0}, 32'd0);
    check("rst_done", {31'b0, done0}, 32'd0);
    check("rst_aborted", {31'b0, ab0}, 32'd0);
    check("rst_tvalid", {31'b0, bus0.cmd_out_TVALID}, 32'd0);
    check("rst_tdata", bus0.cmd_out_TDATA, 32'd0);
    check("rst_rd_en", {31'b0, bus0.img_rd_en}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Basic load: 8 writes, 16 beats.
    run_load(1'b0, 12'd5, 11'd3, 5'd1, 5'd2, -1, -1);
    // All counts zero: only the PROG writes, no reads.
    run_load(1'b0, 12'd5, 11'd0, 5'd0, 5'd0, -1, -1);
    // GAP=3 with two instructions: done at cycle 21.
    run_load(1'b1, 12'd9, 11'd2, 5'd0, 5'd0, -1, -1);
    // Abort on the data beat of the first INST write -> 6 beats.
    run_load(1'b0, 12'd5, 11'd10, 5'd0, 5'd0, 1, -1);
    // Abort on the data beat of the second INST write -> 8 beats.
    run_load(1'b0, 12'd5, 11'd10, 5'd0, 5'd0, 2, -1);
    // Abort during IMM with GAP=3: pair and its gap complete first.
    run_load(1'b1, 12'd3, 11'd1, 5'd2, 5'd3, 4, -1);
    // Clamp of n_jmp/n_imm, start pulsed while busy, aborted cleared.
    run_load(1'b0, 12'hABC, 11'd3, 5'd20, 5'd31, -1, 10);
    // n_inst clamp to 1024; last address is 2^10+31.
    run_load(1'b0, 12'd1, 11'd2047, 5'd16, 5'd16, -1, -1);

    // Reset in the middle of the INST phase.
    mon_en = 1'b0;
    @(negedge clk);
    sel = 1'b0; dest_id = 12'd7; n_inst = 11'd10; n_jmp = '0; n_imm = '0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_busy", {31'b0, busy0}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("arst_tvalid", {31'b0, bus0.cmd_out_TVALID}, 32'd0);
    check("arst_ready", {31'b0, sr0}, 32'd1);
    check("arst_busy", {31'b0, busy0}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    run_load(1'b0, 12'd7, 11'd10, 5'd0, 5'd0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
